// File: rtl/cpu_decode_stage_if.sv
// Fetch, register-file, writeback and ID/EX signal bundle for the decode stage.
// master = decode stage, slave = surrounding pipeline.
interface cpu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            hz_stall;
  logic [4:0]      r1;
  logic [4:0]      r2;
  logic [XLEN-1:0] q1;
  logic [XLEN-1:0] q2;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_imm;
  logic [2:0]      id_funct3;
  logic [3:0]      id_alu_op;
  logic            id_src_a_pc;
  logic            id_src_b_imm;
  logic            id_reg_write;
  logic            id_is_load;
  logic            id_is_store;
  logic            id_is_branch;
  logic            id_is_jal;
  logic            id_is_jalr;
  logic            id_illegal;

  modport master (
    input  if_valid, if_instr, if_pc, q1, q2, wb_we, wb_rd, wb_data,
    output hz_stall, r1, r2,
    output id_valid, id_pc, id_rs1_val, id_rs2_val, id_rs1, id_rs2, id_rd, id_imm,
    output id_funct3, id_alu_op, id_src_a_pc, id_src_b_imm, id_reg_write,
    output id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr, id_illegal
  );

  modport slave (
    output if_valid, if_instr, if_pc, q1, q2, wb_we, wb_rd, wb_data,
    input  hz_stall, r1, r2,
    input  id_valid, id_pc, id_rs1_val, id_rs2_val, id_rs1, id_rs2, id_rd, id_imm,
    input  id_funct3, id_alu_op, id_src_a_pc, id_src_b_imm, id_reg_write,
    input  id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr, id_illegal
  );
endinterface

// File: rtl/cpu_decode_stage.sv
// RV32I decode stage: immediate/control generation, operand capture with WB bypass,
// load-use bubble insertion and the ID/EX pipeline register.
module cpu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_pipeline,
  input  logic                flush,
  cpu_decode_stage_if.master  bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            illegal;
  } idex_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
    return XLEN'($signed(ins[31:20]));
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
    return XLEN'($signed({ins[31:25], ins[11:7]}));
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] ins);
    return XLEN'($signed({ins[31:12], 12'd0}));
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  endfunction

  // funct7[5] only qualifies ADD/SUB for register-register ops; shifts always use it
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                                input logic is_reg_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] pick_operand(input logic [4:0] addr,
                                                   input logic [XLEN-1:0] rf_data,
                                                   input logic we, input logic [4:0] wrd,
                                                   input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] v;
    if (addr == 5'd0) begin
      v = '0;
    end else if (we && (wrd == addr)) begin
      v = wdata;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  function automatic idex_t make_bubble(input idex_t p);
    idex_t b;
    b           = p;
    b.valid     = 1'b0;
    b.reg_write = 1'b0;
    b.is_load   = 1'b0;
    b.is_store  = 1'b0;
    b.is_branch = 1'b0;
    b.is_jal    = 1'b0;
    b.is_jalr   = 1'b0;
    b.illegal   = 1'b0;
    return b;
  endfunction

  logic [6:0] opcode_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] rd_s;
  logic [2:0] funct3_s;
  logic       f7b5_s;
  logic       uses_rs1_s;
  logic       uses_rs2_s;
  logic       hz_s;
  idex_t      dec_s;
  idex_t      idex_d;
  idex_t      idex_q;

  assign opcode_s = bus.if_instr[6:0];
  assign rd_s     = bus.if_instr[11:7];
  assign funct3_s = bus.if_instr[14:12];
  assign rs1_s    = bus.if_instr[19:15];
  assign rs2_s    = bus.if_instr[24:20];
  assign f7b5_s   = bus.if_instr[30];

  assign bus.r1 = rs1_s;
  assign bus.r2 = rs2_s;

  // Combinational decode of the fetched instruction into an ID/EX payload
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = bus.if_valid;
    dec_s.pc      = bus.if_pc;
    dec_s.rs1     = rs1_s;
    dec_s.rs2     = rs2_s;
    dec_s.rd      = rd_s;
    dec_s.funct3  = funct3_s;
    dec_s.rs1_val = pick_operand(rs1_s, bus.q1, bus.wb_we, bus.wb_rd, bus.wb_data);
    dec_s.rs2_val = pick_operand(rs2_s, bus.q2, bus.wb_we, bus.wb_rd, bus.wb_data);
    dec_s.alu_op  = ALU_ADD;
    case (opcode_s)
      OPC_LUI: begin
        dec_s.imm = imm_u(bus.if_instr); dec_s.alu_op = ALU_PASSB;
        dec_s.src_b_imm = 1'b1; dec_s.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.imm = imm_u(bus.if_instr); dec_s.src_a_pc = 1'b1;
        dec_s.src_b_imm = 1'b1; dec_s.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec_s.imm = imm_j(bus.if_instr); dec_s.src_a_pc = 1'b1;
        dec_s.src_b_imm = 1'b1; dec_s.reg_write = 1'b1; dec_s.is_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_s.imm = imm_i(bus.if_instr); dec_s.src_b_imm = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        dec_s.imm = imm_b(bus.if_instr); dec_s.alu_op = ALU_SUB; dec_s.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        dec_s.imm = imm_i(bus.if_instr); dec_s.src_b_imm = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.is_load = 1'b1;
      end
      OPC_STORE: begin
        dec_s.imm = imm_s(bus.if_instr); dec_s.src_b_imm = 1'b1; dec_s.is_store = 1'b1;
      end
      OPC_OPIMM: begin
        dec_s.imm = imm_i(bus.if_instr); dec_s.src_b_imm = 1'b1; dec_s.reg_write = 1'b1;
        dec_s.alu_op = alu_from_funct(funct3_s, f7b5_s, 1'b0);
      end
      OPC_OP: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_op = alu_from_funct(funct3_s, f7b5_s, 1'b1);
      end
      default: dec_s.illegal = 1'b1;
    endcase
    dec_s.reg_write = dec_s.reg_write & (rd_s != 5'd0);
  end

  // Load-use detection against the load currently sitting in ID/EX
  always_comb begin
    uses_rs1_s = !((opcode_s == OPC_LUI) || (opcode_s == OPC_AUIPC) || (opcode_s == OPC_JAL));
    uses_rs2_s = (opcode_s == OPC_OP) || (opcode_s == OPC_STORE) || (opcode_s == OPC_BRANCH);
    hz_s = idex_q.valid & idex_q.is_load & (idex_q.rd != 5'd0) &
           ((uses_rs1_s & (idex_q.rd == rs1_s)) | (uses_rs2_s & (idex_q.rd == rs2_s)));
  end

  assign bus.hz_stall = hz_s & bus.if_valid & ~flush;

  // ID/EX next state: freeze, then squash (flush, hazard or empty slot), then load
  always_comb begin
    idex_d = idex_q;
    if (stall_pipeline) begin
      idex_d = idex_q;
    end else if (flush || hz_s || !bus.if_valid) begin
      idex_d = make_bubble(dec_s);
    end else begin
      idex_d = dec_s;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.id_valid     = idex_q.valid;
  assign bus.id_pc        = idex_q.pc;
  assign bus.id_rs1_val   = idex_q.rs1_val;
  assign bus.id_rs2_val   = idex_q.rs2_val;
  assign bus.id_rs1       = idex_q.rs1;
  assign bus.id_rs2       = idex_q.rs2;
  assign bus.id_rd        = idex_q.rd;
  assign bus.id_imm       = idex_q.imm;
  assign bus.id_funct3    = idex_q.funct3;
  assign bus.id_alu_op    = idex_q.alu_op;
  assign bus.id_src_a_pc  = idex_q.src_a_pc;
  assign bus.id_src_b_imm = idex_q.src_b_imm;
  assign bus.id_reg_write = idex_q.reg_write;
  assign bus.id_is_load   = idex_q.is_load;
  assign bus.id_is_store  = idex_q.is_store;
  assign bus.id_is_branch = idex_q.is_branch;
  assign bus.id_is_jal    = idex_q.is_jal;
  assign bus.id_is_jalr   = idex_q.is_jalr;
  assign bus.id_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed-vector bench for cpu_decode_stage with hand-computed expectations.
module tb_cpu_decode_stage;

  logic clk;
  logic rst;
  logic stall_pipeline;
  logic flush;
  int   n_vec;
  int   n_err;

  cpu_decode_stage_if #(.XLEN(32)) bus ();

  cpu_decode_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pipeline (stall_pipeline),
    .flush          (flush),
    .bus            (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    stall_pipeline = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0000_0000, 32'h0000_0000);
    bus.q1 = 32'd0; bus.q2 = 32'd0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    repeat (2) tick();
    check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_alu", 32'(bus.id_alu_op), 32'd0);
    check_eq("rst_pc", bus.id_pc, 32'd0);
    check_eq("rst_imm", bus.id_imm, 32'd0);
    rst = 1'b0;

    // addi x5,x0,7
    drive(1'b1, 32'h0070_0293, 32'h0000_0100);
    bus.q1 = 32'hDEAD_BEEF;
    #1;
    check_eq("addi_r1", 32'(bus.r1), 32'd0);
    check_eq("addi_r2", 32'(bus.r2), 32'd7);
    tick();
    check_eq("addi_valid", 32'(bus.id_valid), 32'd1);
    check_eq("addi_rd", 32'(bus.id_rd), 32'd5);
    check_eq("addi_imm", bus.id_imm, 32'd7);
    check_eq("addi_alu", 32'(bus.id_alu_op), 32'd0);
    check_eq("addi_bimm", 32'(bus.id_src_b_imm), 32'd1);
    check_eq("addi_rw", 32'(bus.id_reg_write), 32'd1);
    check_eq("addi_rs1v", bus.id_rs1_val, 32'd0);
    check_eq("addi_pc", bus.id_pc, 32'h0000_0100);

    // beq x0,x0,-8
    drive(1'b1, 32'hFE00_0CE3, 32'h0000_0104);
    tick();
    check_eq("beq_imm", bus.id_imm, 32'hFFFF_FFF8);
    check_eq("beq_br", 32'(bus.id_is_branch), 32'd1);
    check_eq("beq_rw", 32'(bus.id_reg_write), 32'd0);
    check_eq("beq_alu", 32'(bus.id_alu_op), 32'd1);

    // lw x6,0(x5) then dependent add x7,x6,x5 with rs2 bypass
    drive(1'b1, 32'h0002_A303, 32'h0000_0108);
    bus.q1 = 32'h0000_2000;
    tick();
    check_eq("lw_load", 32'(bus.id_is_load), 32'd1);
    check_eq("lw_rd", 32'(bus.id_rd), 32'd6);
    check_eq("lw_rs1v", bus.id_rs1_val, 32'h0000_2000);
    drive(1'b1, 32'h0053_03B3, 32'h0000_010C);
    bus.q1 = 32'h0000_0055; bus.q2 = 32'd0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_1234;
    #1;
    check_eq("lu_hz", 32'(bus.hz_stall), 32'd1);
    tick();
    check_eq("bub_valid", 32'(bus.id_valid), 32'd0);
    check_eq("bub_load", 32'(bus.id_is_load), 32'd0);
    check_eq("bub_rw", 32'(bus.id_reg_write), 32'd0);
    check_eq("bub_hz", 32'(bus.hz_stall), 32'd0);
    tick();
    check_eq("add_valid", 32'(bus.id_valid), 32'd1);
    check_eq("add_rs1", 32'(bus.id_rs1), 32'd6);
    check_eq("add_rs2", 32'(bus.id_rs2), 32'd5);
    check_eq("add_rd", 32'(bus.id_rd), 32'd7);
    check_eq("add_byp", bus.id_rs2_val, 32'h0000_1234);
    check_eq("add_rs1v", bus.id_rs1_val, 32'h0000_0055);
    check_eq("add_pc", bus.id_pc, 32'h0000_010C);

    // wb_rd = x0 never bypasses
    bus.wb_rd = 5'd0; bus.q2 = 32'h0000_ABCD;
    tick();
    check_eq("nobyp_rs2v", bus.id_rs2_val, 32'h0000_ABCD);
    drive(1'b1, 32'h0000_0433, 32'h0000_0110);
    bus.wb_data = 32'h0000_0999; bus.q1 = 32'h0000_0777; bus.q2 = 32'h0000_0888;
    tick();
    check_eq("x0_rs1v", bus.id_rs1_val, 32'd0);
    check_eq("x0_rs2v", bus.id_rs2_val, 32'd0);
    bus.wb_we = 1'b0;

    // ALU op / immediate variants
    drive(1'b1, 32'h4020_84B3, 32'h0000_0114);
    tick();
    check_eq("sub_alu", 32'(bus.id_alu_op), 32'd1);
    drive(1'b1, 32'h4030_D513, 32'h0000_0118);
    tick();
    check_eq("srai_alu", 32'(bus.id_alu_op), 32'd7);
    check_eq("srai_imm", bus.id_imm, 32'h0000_0403);
    drive(1'b1, 32'hC000_8093, 32'h0000_011C);
    tick();
    check_eq("addin_alu", 32'(bus.id_alu_op), 32'd0);
    check_eq("addin_imm", bus.id_imm, 32'hFFFF_FC00);
    drive(1'b1, 32'h1234_51B7, 32'h0000_0120);
    tick();
    check_eq("lui_alu", 32'(bus.id_alu_op), 32'd10);
    check_eq("lui_imm", bus.id_imm, 32'h1234_5000);
    drive(1'b1, 32'h0080_00EF, 32'h0000_0124);
    tick();
    check_eq("jal_imm", bus.id_imm, 32'd8);
    check_eq("jal_jal", 32'(bus.id_is_jal), 32'd1);
    check_eq("jal_apc", 32'(bus.id_src_a_pc), 32'd1);
    check_eq("jal_rw", 32'(bus.id_reg_write), 32'd1);

    // invalid fetch slot
    drive(1'b0, 32'h0070_0293, 32'h0000_0128);
    tick();
    check_eq("inv_valid", 32'(bus.id_valid), 32'd0);
    check_eq("inv_rw", 32'(bus.id_reg_write), 32'd0);

    // flush alone, then flush colliding with a load-use hazard
    drive(1'b1, 32'h0070_0293, 32'h0000_012C);
    flush = 1'b1;
    tick();
    check_eq("fl_valid", 32'(bus.id_valid), 32'd0);
    flush = 1'b0;
    drive(1'b1, 32'h0002_A303, 32'h0000_0130);
    tick();
    drive(1'b1, 32'h0053_03B3, 32'h0000_0134);
    flush = 1'b1;
    #1;
    check_eq("flhz_hz", 32'(bus.hz_stall), 32'd0);
    tick();
    check_eq("flhz_valid", 32'(bus.id_valid), 32'd0);
    flush = 1'b0;

    // global stall holds ID/EX for 3 cycles
    drive(1'b1, 32'h0070_0293, 32'h0000_0138);
    tick();
    stall_pipeline = 1'b1;
    drive(1'b1, 32'hFE00_0CE3, 32'h0000_013C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stl_valid", 32'(bus.id_valid), 32'd1);
      check_eq("stl_imm", bus.id_imm, 32'd7);
      check_eq("stl_pc", bus.id_pc, 32'h0000_0138);
      check_eq("stl_br", 32'(bus.id_is_branch), 32'd0);
    end
    stall_pipeline = 1'b0;

    // unknown opcode, rd nonzero
    drive(1'b1, 32'h0000_037F, 32'h0000_0140);
    tick();
    check_eq("ill_ill", 32'(bus.id_illegal), 32'd1);
    check_eq("ill_rw", 32'(bus.id_reg_write), 32'd0);
    check_eq("ill_valid", 32'(bus.id_valid), 32'd1);

    // async reset in the middle of a hazard stall
    drive(1'b1, 32'h0002_A303, 32'h0000_0144);
    tick();
    drive(1'b1, 32'h0053_03B3, 32'h0000_0148);
    #1;
    check_eq("rhz_hz", 32'(bus.hz_stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("arst_load", 32'(bus.id_is_load), 32'd0);
    check_eq("arst_pc", bus.id_pc, 32'd0);
    check_eq("arst_hz", 32'(bus.hz_stall), 32'd0);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_decode_stage.md
# cpu_decode_stage

RV32I instruction-decode stage between the fetch unit and the execute stage. It drives the register-file read addresses from the incoming instruction and captures the register-file read data, which arrives combinationally in the same cycle. It generates the immediate and control signals and loads everything into the ID/EX pipeline register. It also detects load-use hazards and inserts one bubble, and honours the global `stall_pipeline` and branch `flush` signals.

## Interface
- `XLEN`, default 32: data and PC width.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: asynchronous, active-high reset.
- `stall_pipeline  in  1`: global freeze. ID/EX holds, and no hazard state advances.
- `flush  in  1`: taken branch/jump from EX. Squash the instruction entering ID/EX.
- `if_valid  in  1`, `if_instr  in  32`, `if_pc  in  XLEN`: fetched instruction.
- `r1  out  5`, `r2  out  5`: register-file read addresses, combinational: `if_instr[19:15]` and `if_instr[24:20]`.
- `q1  in  XLEN`, `q2  in  XLEN`: register-file read data, valid in the same cycle as `r1`/`r2`.
- `wb_we  in  1`, `wb_rd  in  5`, `wb_data  in  XLEN`: writeback port, used for same-cycle bypass.
- `hz_stall  out  1`: combinational request to fetch to hold PC and instruction.
- `id_valid  out  1`, `id_pc  out  XLEN`, `id_rs1_val  out  XLEN`, `id_rs2_val  out  XLEN`, `id_rs1  out  5`, `id_rs2  out  5`, `id_rd  out  5`, `id_imm  out  XLEN`, `id_funct3  out  3`: ID/EX payload.
- `id_alu_op  out  4`: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- `id_src_a_pc  out  1`, `id_src_b_imm  out  1`, `id_reg_write  out  1`, `id_is_load  out  1`, `id_is_store  out  1`, `id_is_branch  out  1`, `id_is_jal  out  1`, `id_is_jalr  out  1`, `id_illegal  out  1`: control outputs.

## Operation
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode sets `id_illegal=1` and `id_reg_write=0`, and the instruction stays valid.
- Immediates are sign-extended to `XLEN`:
  - I-type: `instr[31:20]`.
  - S-type: `{instr[31:25], instr[11:7]}`.
  - B-type: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U-type: `{instr[31:12], 12'b0}`.
  - J-type: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - R-type: 0.
- ALU op selection:
  - OP uses `funct7[5]` to pick SUB or SRA.
  - OP-IMM uses `funct7[5]` only for shifts, so SRAI maps to SRA and ADDI never maps to SUB.
  - LUI maps to PASSB.
  - AUIPC, JAL, LOAD and STORE map to ADD with `id_src_a_pc` set as appropriate.
  - BRANCH maps to SUB.
- `id_reg_write=0` for STORE and BRANCH, and whenever rd is x0.
- Bypass: if `wb_we` is high, `wb_rd` is nonzero and `wb_rd` equals rs1 (or rs2), capture `wb_data` instead of `q1` (or `q2`). An address of x0 always captures 0.
- Load-use hazard:
  - Condition: `hz = id_valid & id_is_load & id_rd!=0 & ((uses_rs1 & id_rd==rs1) | (uses_rs2 & id_rd==rs2))`.
  - `uses_rs1` is false for LUI, AUIPC and JAL.
  - `uses_rs2` is true only for OP, STORE and BRANCH.
- `hz_stall = hz & if_valid & ~flush`.
- Update priority on each clock edge:
  1. `rst`: all outputs go to 0.
  2. `stall_pipeline`: hold all ID/EX outputs.
  3. `flush`: `id_valid` goes to 0 and the payload is don't-care.
  4. `hz`: bubble. `id_valid=0`, and every control bit (`reg_write`, `is_load`, `is_store`, `is_branch`, `is_jal`, `is_jalr`, `illegal`) goes to 0.
  5. Otherwise load the decoded instruction with `id_valid = if_valid`.
- An invalid input (`if_valid=0`) loads `id_valid=0` and zeroes all control bits.

## Timing
- Decode latency is 1 cycle, from `if_instr` to the `id_*` outputs.
- `r1`, `r2` and `hz_stall` are purely combinational.
- A load-use hazard costs exactly 1 bubble cycle:
  - The dependent instruction is held by fetch while `hz_stall=1`.
  - On the next cycle ID/EX holds the bubble, so `hz` clears.
  - The dependent instruction is then loaded.
- Asynchronous `rst` asserted mid-stall clears `id_valid` immediately. `hz_stall` drops because `id_valid=0`.
- `flush` together with `hz` in the same cycle: flush wins and `hz_stall=0`.
- `stall_pipeline` together with `hz`: hold. `hz_stall` may stay high, and fetch also obeys `stall_pipeline`.
- Reset values: every registered output is 0, including `id_pc`, `id_imm` and `id_alu_op=ADD`.

## Test plan
- Reset: assert `rst` mid-cycle -> all `id_*` outputs are 0 immediately, with no clock edge needed.
- `addi x5,x0,7` (0x00700293), valid -> next cycle `id_valid=1`, `id_rd=5`, `id_imm=7`, `id_alu_op=0`, `id_src_b_imm=1`, `id_reg_write=1`, `id_rs1_val=0`.
- `beq x0,x0,-8` (0xFE000CE3) -> `id_imm=0xFFFFFFF8`, `id_is_branch=1`, `id_reg_write=0`, `id_alu_op=1`.
- `lw x6,0(x5)` (0x0002A303) followed by `add x7,x6,x5` (0x005303B3):
  - -> `hz_stall=1` for one cycle and a bubble with `id_valid=0`.
  - -> then the add appears with `id_rs1=6`, `id_rs2=5`.
- Bypass: `wb_we=1`, `wb_rd=5`, `wb_data=0x1234`, `q2=0` while decoding the add -> `id_rs2_val=0x1234`. With `wb_rd=0` -> the bypass is ignored.
- `flush=1` during a valid instruction -> `id_valid=0`. `stall_pipeline=1` for 3 cycles -> `id_*` outputs unchanged throughout.
- Opcode 0x7F -> `id_illegal=1`, `id_reg_write=0`.
